// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the iterative AES encryption core.
//   - FSM state and key-step type enums
//   - GF(2^8) helpers (xtime, gf_mul), S-box, rcon table
//   - AES round primitives (SubBytes, ShiftRows, MixColumns, full/final round)
//   - round-count derivation from key length
// State byte ordering: byte 0 is bits [127:120]; byte (r + 4*c) is row r, column c.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    // STEP_A: RotWord + SubWord + rcon; STEP_B: SubWord only (AES-256 odd groups).
    typedef enum logic {
        STEP_A = 1'b0,
        STEP_B = 1'b1
    } key_step_e;

    function automatic int nr_of(input int key_bits);
        return (key_bits == 128) ? 10 : 14;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (a^254) followed by the affine map.
    // a^254 is built as ((a^127)^2), with a^(2k+1) = (a^k)^2 * a. inv(0) = 0 falls out.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] inv;
        t = a;
        for (int i = 0; i < 6; i++) begin
            t = gf_mul(gf_mul(t, t), a);
        end
        inv = gf_mul(t, t);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Row r is rotated left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s));
        if (!last) t = mix_columns(t);
        return t ^ rk;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one update of the on-the-fly key-expansion window.
//   clk      in   clock for the optional retiming stages
//   win_i    in   current key window (4 words for AES-128, 8 words for AES-256)
//   step_i   in   STEP_A (RotWord+SubWord+rcon) or STEP_B (SubWord only)
//   rcon_i   in   round constant byte used by STEP_A
//   rk_o     out  round key for the round that consumes this window (combinational)
//   next_q_o out  updated window, delayed by STAGES registers
// Window layout: oldest word in the MSBs. For AES-256 the updated window is
// {old lower half, four new words}, so its upper half is the current lower half.
module aes_key_step
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 256,
    parameter int STAGES   = 1
) (
    input  logic                clk,
    input  logic [KEY_BITS-1:0] win_i,
    input  key_step_e           step_i,
    input  logic [7:0]          rcon_i,
    output logic [127:0]        rk_o,
    output logic [KEY_BITS-1:0] next_q_o
);

    logic [31:0]         last_w;
    logic [31:0]         f_w;
    logic [127:0]        old_h;
    logic [31:0]         n0, n1, n2, n3;
    logic [KEY_BITS-1:0] next_w;

    assign last_w = win_i[31:0];
    assign old_h  = win_i[KEY_BITS-1 -: 128];

    always_comb begin
        f_w = sub_word(last_w);
        if (step_i == STEP_A) begin
            f_w = sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon_i, 24'h000000};
        end
    end

    assign n0 = old_h[127:96] ^ f_w;
    assign n1 = old_h[95:64]  ^ n0;
    assign n2 = old_h[63:32]  ^ n1;
    assign n3 = old_h[31:0]   ^ n2;

    generate
        if (KEY_BITS == 128) begin : g_k128
            assign next_w = {n0, n1, n2, n3};
        end else begin : g_k256
            assign next_w = {win_i[127:0], n0, n1, n2, n3};
        end
    endgenerate

    // AES-128: key of round r is the window after r updates (the new words).
    // AES-256: key of round r is the lower half of the window before update r.
    assign rk_o = next_w[KEY_BITS-1 -: 128];

    generate
        if (STAGES == 0) begin : g_no_pipe
            assign next_q_o = next_w;
        end else begin : g_pipe
            logic [KEY_BITS-1:0] pipe_q [STAGES];
            always_ff @(posedge clk) begin
                pipe_q[0] <= next_w;
                for (int i = 1; i < STAGES; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign next_q_o = pipe_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/AES-256 encryption core, one round datapath
// reused NR times, each round spanning ROUND_CYCLES cycles.
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   plaintext/key presented
//   in_ready   out  core can accept (IDLE, or DONE while out_ready=1)
//   in_state   in   128-bit plaintext
//   in_key     in   KEY_BITS cipher key
//   out_valid  out  ciphertext available
//   out_ready  in   consumer accepts
//   out_data   out  128-bit ciphertext, held stable while out_valid=1
//   busy       out  high from acceptance until the output handshake completes
// Handshakes: a transfer happens on a clk edge where valid and ready are both 1;
// valid never drops without a transfer and ready never depends on a later cycle.
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS     = 256,
    parameter int ROUND_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_state,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam int         NR         = nr_of(KEY_BITS);
    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic [1:0] LAST_SUB   = 2'(ROUND_CYCLES - 1);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
            $error("aes_iter_core: KEY_BITS must be 128 or 256");
        end
        if (ROUND_CYCLES < 1 || ROUND_CYCLES > 4) begin : g_bad_rc
            $error("aes_iter_core: ROUND_CYCLES must be 1..4");
        end
    endgenerate

    aes_state_e          state_q, state_d;
    logic [127:0]        s_q, s_d;
    logic [127:0]        out_q, out_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [3:0]          round_q, round_d;
    logic [1:0]          sub_q, sub_d;
    // Holds in_ready low until the first edge after reset is released.
    logic                rdy_en_q;

    key_step_e           step_sel;
    logic [3:0]          rcon_idx;
    logic [127:0]        rk;
    logic [KEY_BITS-1:0] key_next;
    logic [127:0]        round_comb;
    logic [127:0]        round_out;
    logic                accept;

    // Update r (applied at the end of round r): AES-128 always STEP_A with
    // rcon[r-1]; AES-256 alternates A (odd r) / B (even r), rcon per A step.
    always_comb begin
        if (KEY_BITS == 128) begin
            step_sel = STEP_A;
            rcon_idx = round_q - 4'd1;
        end else begin
            step_sel = round_q[0] ? STEP_A : STEP_B;
            rcon_idx = (round_q - 4'd1) >> 1;
        end
    end

    aes_key_step #(
        .KEY_BITS (KEY_BITS),
        .STAGES   (ROUND_CYCLES - 1)
    ) u_key_step (
        .clk      (clk),
        .win_i    (key_q),
        .step_i   (step_sel),
        .rcon_i   (rcon_lut(rcon_idx)),
        .rk_o     (rk),
        .next_q_o (key_next)
    );

    assign round_comb = aes_round(s_q, rk, round_q == LAST_ROUND);

    // Retiming stages: s_q/key_q are stable for a whole round, so after
    // ROUND_CYCLES-1 cycles the delayed value equals the round result.
    generate
        if (ROUND_CYCLES == 1) begin : g_no_pipe
            assign round_out = round_comb;
        end else begin : g_pipe
            logic [127:0] pipe_q [ROUND_CYCLES-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= round_comb;
                for (int i = 1; i < ROUND_CYCLES - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign round_out = pipe_q[ROUND_CYCLES-2];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        out_d     = out_q;
        key_d     = key_q;
        round_d   = round_q;
        sub_d     = sub_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = rdy_en_q;
                accept   = in_valid & rdy_en_q;
            end
            ROUND: begin
                if (sub_q == LAST_SUB) begin
                    s_d   = round_out;
                    key_d = key_next;
                    sub_d = 2'd0;
                    if (round_q == LAST_ROUND) begin
                        out_d   = round_out;
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    sub_d = sub_q + 2'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) accept = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Acceptance (from IDLE or back-to-back from DONE): initial AddRoundKey.
        if (accept) begin
            s_d     = in_state ^ in_key[KEY_BITS-1 -: 128];
            key_d   = in_key;
            round_d = 4'd1;
            sub_d   = 2'd0;
            state_d = ROUND;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            out_q    <= '0;
            key_q    <= '0;
            round_q  <= '0;
            sub_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            out_q    <= out_d;
            key_q    <= key_d;
            round_q  <= round_d;
            sub_q    <= sub_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign out_data = out_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: directed-vector bench for aes_iter_core.
// Four instances: [0] AES-256 RC=2, [1] AES-128 RC=2, [2] AES-256 RC=1, [3] AES-256 RC=4.
// Expected ciphertexts are published FIPS-197 / SP800-38A values.
module tb_aes_iter_core;

    localparam int NDUT = 4;
    localparam int LAT [NDUT] = '{28, 20, 14, 56};
    localparam int WAIT_LIM = 200;

    localparam logic [127:0] PT_F     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K256_F   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K128_F   = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT256_F  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128_F  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K128_B   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT128_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_S1    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT_S2    = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] PT_S3    = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] CT128_S1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [255:0] K256_S   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] CT256_S1 = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
    localparam logic [127:0] CT256_S2 = 128'h591ccb10d410ed26dc5ba74a31362870;
    localparam logic [127:0] CT256_S3 = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUTs ----------------
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic         busy      [NDUT];
    logic [127:0] in_state  [NDUT];
    logic [127:0] out_data  [NDUT];
    logic [255:0] in_key    [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int KB = (g == 1) ? 128 : 256;
        localparam int RC = (g == 2) ? 1 : ((g == 3) ? 4 : 2);
        aes_iter_core #(
            .KEY_BITS     (KB),
            .ROUND_CYCLES (RC)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_key    (in_key[g][KB-1:0]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    // ---------------- scoreboard ----------------
    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_in(input int d, input logic [127:0] pt, input logic [255:0] key);
        in_valid[d] = 1'b1;
        in_state[d] = pt;
        in_key[d]   = key;
    endtask

    // Called at a negedge with in_valid set; returns the index of the accepting edge.
    task automatic wait_ready(input int d, input string tag, output int acc_edge);
        int n;
        n = 0;
        while (!in_ready[d] && n < WAIT_LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIM) check_eq({tag, "_ready_timeout"}, {127'd0, in_ready[d]}, 128'd1);
        acc_edge = cyc + 1;
    endtask

    // Waits at negedges for out_valid; counts samples where busy was low meanwhile.
    task automatic wait_out(input int d, input string tag, output int v_cyc, output int busy_low);
        int n;
        n = 0;
        busy_low = 0;
        while (!out_valid[d] && n < WAIT_LIM) begin
            if (!busy[d]) busy_low++;
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIM) check_eq({tag, "_out_timeout"}, {127'd0, out_valid[d]}, 128'd1);
        v_cyc = cyc;
    endtask

    // One isolated block with out_ready=1: latency, busy, data, return to IDLE.
    task automatic run_one(input int d, input string tag, input logic [127:0] pt,
                           input logic [255:0] key, input logic [127:0] ct);
        int acc, vc, bl;
        out_ready[d] = 1'b1;
        drive_in(d, pt, key);
        exp_q.push_back(ct);
        wait_ready(d, tag, acc);
        @(negedge clk);
        in_valid[d] = 1'b0;
        check_eq({tag, "_busy_after_accept"}, {127'd0, busy[d]}, 128'd1);
        wait_out(d, tag, vc, bl);
        check_eq({tag, "_latency"}, vc - acc, LAT[d]);
        check_eq({tag, "_busy_low_samples"}, bl, 0);
        check_eq({tag, "_data"}, out_data[d], exp_q.pop_front());
        @(negedge clk);
        check_eq({tag, "_valid_after_hs"}, {127'd0, out_valid[d]}, 128'd0);
        check_eq({tag, "_busy_after_hs"}, {127'd0, busy[d]}, 128'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, vc, bl;
        logic [127:0] pts [4];
        logic [127:0] cts [4];
        logic [255:0] keys [4];

        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            in_valid[d]  = 1'b0;
            in_state[d]  = '0;
            in_key[d]    = '0;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);

        // Reset state of every instance
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("rst%0d_out_valid", d), {127'd0, out_valid[d]}, 128'd0);
            check_eq($sformatf("rst%0d_busy", d), {127'd0, busy[d]}, 128'd0);
            check_eq($sformatf("rst%0d_in_ready", d), {127'd0, in_ready[d]}, 128'd0);
            check_eq($sformatf("rst%0d_out_data", d), out_data[d], 128'd0);
        end
        rst_n = 1'b1;
        check_eq("rst_in_ready_before_edge", {127'd0, in_ready[0]}, 128'd0);
        @(negedge clk);
        check_eq("rst_in_ready_after_edge", {127'd0, in_ready[0]}, 128'd1);

        // AES-128 vectors, RC=2
        run_one(1, "t1_fips128", PT_F, K128_F, CT128_F);
        run_one(1, "t1_appb128", PT_B, K128_B, CT128_B);
        run_one(1, "t1_sp128", PT_S1, K128_B, CT128_S1);

        // AES-256, RC=2 / RC=1 / RC=4
        run_one(0, "t2_fips256", PT_F, K256_F, CT256_F);
        run_one(2, "t6_rc1", PT_F, K256_F, CT256_F);
        run_one(3, "t6_rc4", PT_F, K256_F, CT256_F);

        // Backpressure: out_ready low for 10 cycles, in_valid pulses ignored
        out_ready[0] = 1'b0;
        drive_in(0, PT_S1, K256_S);
        exp_q.push_back(CT256_S1);
        wait_ready(0, "t3", acc);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_out(0, "t3", vc, bl);
        check_eq("t3_latency", vc - acc, LAT[0]);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = (i % 2 == 0);
            in_state[0] = PT_F;
            in_key[0]   = K256_F;
            @(negedge clk);
            check_eq($sformatf("t3_hold%0d_data", i), out_data[0], exp_q[0]);
            check_eq($sformatf("t3_hold%0d_valid", i), {127'd0, out_valid[0]}, 128'd1);
            check_eq($sformatf("t3_hold%0d_in_ready", i), {127'd0, in_ready[0]}, 128'd0);
        end
        in_valid[0] = 1'b0;
        void'(exp_q.pop_front());
        out_ready[0] = 1'b1;
        @(negedge clk);
        check_eq("t3_valid_after_release", {127'd0, out_valid[0]}, 128'd0);
        check_eq("t3_busy_after_release", {127'd0, busy[0]}, 128'd0);
        check_eq("t3_in_ready_idle", {127'd0, in_ready[0]}, 128'd1);
        @(negedge clk);
        check_eq("t3_no_second_hs", {127'd0, out_valid[0]}, 128'd0);
        check_eq("t3_no_stray_accept", {127'd0, busy[0]}, 128'd0);

        // Back-to-back: in_valid and out_ready held high, 4 blocks
        pts  = '{PT_S1, PT_S2, PT_S3, PT_F};
        keys = '{K256_S, K256_S, K256_S, K256_F};
        cts  = '{CT256_S1, CT256_S2, CT256_S3, CT256_F};
        drive_in(0, pts[0], keys[0]);
        exp_q.push_back(cts[0]);
        wait_ready(0, "t4", acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) begin
                drive_in(0, pts[k+1], keys[k+1]);
                exp_q.push_back(cts[k+1]);
            end else begin
                in_valid[0] = 1'b0;
            end
            wait_out(0, "t4", vc, bl);
            check_eq($sformatf("t4_blk%0d_latency", k), vc - acc, LAT[0]);
            check_eq($sformatf("t4_blk%0d_data", k), out_data[0], exp_q.pop_front());
            if (k < 3) begin
                // The next block is accepted on the same edge as this output handshake.
                check_eq($sformatf("t4_blk%0d_in_ready", k), {127'd0, in_ready[0]}, 128'd1);
                acc = cyc + 1;
            end
        end
        @(negedge clk);
        check_eq("t4_valid_end", {127'd0, out_valid[0]}, 128'd0);
        check_eq("t4_busy_end", {127'd0, busy[0]}, 128'd0);

        // Reset in the middle of a block
        drive_in(0, PT_F, K256_F);
        wait_ready(0, "t5", acc);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t5_rst_out_valid", {127'd0, out_valid[0]}, 128'd0);
        check_eq("t5_rst_busy", {127'd0, busy[0]}, 128'd0);
        check_eq("t5_rst_out_data", out_data[0], 128'd0);
        check_eq("t5_rst_in_ready", {127'd0, in_ready[0]}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t5_in_ready_after", {127'd0, in_ready[0]}, 128'd1);
        run_one(0, "t5_fresh", PT_S2, K256_S, CT256_S2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
